// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: default data width, a data type of that
// width and the register-slice occupancy states.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;

    typedef logic [AXIS_DATA_WIDTH-1:0] axis_data_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } axis_reg_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Full AXI4-Stream register slice: a main register drives the downstream
// port and a skid register catches the one beat that can arrive in the
// cycle the registered upstream ready is still high after a stall.
//
// state | meaning
// EMPTY | nothing stored, m_valid=0, s_ready=1
// ONE   | main register holds a beat, m_valid=1, s_ready=1
// FULL  | main and skid hold beats, m_valid=1, s_ready=0
//
// tvalid and tready are registered copies of the decoded next state, so no
// input reaches an output combinationally. The ready register is cleared by
// reset separately from the state so that upstream sees ready low during
// reset and high only from the cycle after the first released edge.
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i
);

    axis_reg_state_e       state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  vld_q, vld_d;
    logic                  rdy_q, rdy_d;
    logic                  s_in;
    logic                  m_out;

    assign s_in  = s_axis_tvalid_i & rdy_q;
    assign m_out = vld_q & m_axis_tready_i;

    // Next occupancy state and data register updates from the two handshakes.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (s_in) begin
                    state_d = ONE;
                    main_d  = s_axis_tdata_i;
                end
            end
            ONE: begin
                if (s_in && m_out) begin
                    main_d = s_axis_tdata_i;
                end else if (s_in) begin
                    state_d = FULL;
                    skid_d  = s_axis_tdata_i;
                end else if (m_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (m_out) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Handshake outputs for the coming cycle, decoded from the next state.
    always_comb begin
        vld_d = (state_d != EMPTY);
        rdy_d = (state_d != FULL);
    end

    // State, data and handshake registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign s_axis_tready_o = rdy_q;
    assign m_axis_tvalid_o = vld_q;
    assign m_axis_tdata_o  = main_q;

endmodule

// File: tb/tb_axis_reg_slice.sv
// Directed and random bench for axis_reg_slice. A reference model tracks the
// expected occupancy (queue of beats) and the expected ready/valid; every
// cycle the DUT outputs are compared against it before the next edge.
module tb_axis_reg_slice;

    logic        clk_i;
    logic        arstn_i;
    logic [31:0] s_axis_tdata_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tready_o;
    logic [31:0] m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;

    axis_reg_slice #(.DATA_WIDTH(32)) dut (
        .clk_i           (clk_i),
        .arstn_i         (arstn_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          errors   = 0;
    int          accepted = 0;
    logic [31:0] exp_q[$];
    logic        rdy_en   = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] data_prev  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare registered outputs against the model,
    // advance the model, then move to just after the next rising edge.
    task automatic step(input logic v, input logic [31:0] d, input logic mr, input logic rn);
        logic exp_vld;
        logic exp_rdy;
        logic acc;
        logic dlv;
        s_axis_tvalid_i = v;
        s_axis_tdata_i  = d;
        m_axis_tready_i = mr;
        arstn_i         = rn;
        exp_vld = (exp_q.size() > 0);
        exp_rdy = rdy_en && (exp_q.size() < 2);
        chk("m_valid", {31'b0, m_axis_tvalid_o}, {31'b0, exp_vld});
        chk("s_ready", {31'b0, s_axis_tready_o}, {31'b0, exp_rdy});
        if (exp_vld) chk("m_data", m_axis_tdata_o, exp_q[0]);
        if (stall_prev) chk("stall_stable", m_axis_tdata_o, data_prev);
        stall_prev = rn && exp_vld && !mr;
        data_prev  = m_axis_tdata_o;
        if (!rn) begin
            exp_q.delete();
            rdy_en = 1'b0;
        end else begin
            acc = v && exp_rdy;
            dlv = exp_vld && mr;
            if (dlv) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(d);
                accepted++;
            end
            rdy_en = 1'b1;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int cyc;
        s_axis_tvalid_i = 1'b0;
        s_axis_tdata_i  = '0;
        m_axis_tready_i = 1'b0;
        arstn_i         = 1'b0;
        @(posedge clk_i);
        #1;

        // Reset held for 5 clocks; outputs checked inside each step.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        chk("reset_data", m_axis_tdata_o, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("ready_after_release", {31'b0, s_axis_tready_o}, 32'h1);

        // Single beat.
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        chk("single_data", m_axis_tdata_o, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("single_gone", {31'b0, m_axis_tvalid_o}, 32'h0);

        // Streaming 0..15 back-to-back.
        for (int i = 0; i < 16; i++) step(1'b1, i, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Backpressure: two beats into a stalled slice.
        step(1'b1, 32'hA, 1'b0, 1'b1);
        step(1'b1, 32'hB, 1'b0, 1'b1);
        chk("bp_ready_low", {31'b0, s_axis_tready_o}, 32'h0);
        chk("bp_hold_a", m_axis_tdata_o, 32'hA);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_then_b", m_axis_tdata_o, 32'hB);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("bp_ready_back", {31'b0, s_axis_tready_o}, 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Random valid/ready, 1000 accepted beats, bounded by a cycle budget.
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
            cyc++;
        end
        chk("random_budget", {31'b0, (accepted >= 1000)}, 32'h1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            cyc++;
        end
        chk("random_drained", exp_q.size(), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Reset while FULL: stored beats must never show up afterwards.
        step(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        step(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        chk("full_ready_low", {31'b0, s_axis_tready_o}, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_reset_valid", {31'b0, m_axis_tvalid_o}, 32'h0);
        chk("full_reset_data", m_axis_tdata_o, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h5000 + i, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
